id_imm_gen_stage: RTL and testbench

Registered immediate generator for the ID stage. It decodes every RV32I/RV64I immediate format (I, S, B, U, J) from a fetched instruction. It sign-extends the immediate to XLEN and forwards it with the PC and instruction through a valid/ready pipeline register with an optional skid buffer. It sits between the IF/ID boundary and the register-read/execute path, and it flags opcodes it does not recognise.

---
 rtl/id_imm_pkg.sv | 32 +++
 rtl/id_imm_gen_stage_if.sv | 28 ++
 rtl/id_imm_gen_stage_decode.sv | 70 +++++++
 rtl/id_imm_gen_stage.sv | 128 ++++++++++++
 tb/tb_id_imm_gen_stage.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_imm_pkg.sv
// Shared encodings for the ID-stage immediate generator: RISC-V major opcodes,
// immediate format codes and the skid-buffer occupancy states.
package id_imm_pkg;

  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/id_imm_gen_stage_if.sv
// Valid/ready bundle between the IF/ID boundary, the immediate stage and the
// register-read path; the stage itself uses the slave view.
interface id_imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
  );
endinterface

// File: rtl/id_imm_gen_stage_decode.sv
// Combinational RV32I/RV64I immediate decoder: format, sign-extended
// immediate and an illegal flag for anything it does not recognise.
module id_imm_decode
  import id_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (inst[6:0])
        LUI, AUIPC: begin
          imm32 = {inst[31:12], 12'h000};
          fmt   = FMT_U;
        end
        JAL: begin
          imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
          fmt   = FMT_J;
        end
        BRANCH: begin
          imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
          fmt   = FMT_B;
        end
        STORE: begin
          imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
          fmt   = FMT_S;
        end
        JALR, LOAD, OP_IMM, MISC_MEM, SYSTEM: begin
          imm32 = {{20{inst[31]}}, inst[31:20]};
          fmt   = FMT_I;
        end
        OP: ;
        // The W-suffixed opcodes only exist on RV64.
        OP_IMM_32: begin
          if (XLEN == 64) begin
            imm32 = {{20{inst[31]}}, inst[31:20]};
            fmt   = FMT_I;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_32: begin
          if (XLEN != 64) illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  generate
    if (XLEN == 64) begin : g_ext64
      assign imm = {{32{imm32[31]}}, imm32};
    end else begin : g_ext32
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/id_imm_gen_stage.sv
// ID-stage immediate generator: decodes on the input side and carries the
// result, PC and instruction through a valid/ready register or skid buffer.
module id_imm_gen_stage
  import id_imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input logic              clk,
  input logic              rst,
  id_imm_gen_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;
  entry_t          main_reg;
  logic            out_valid_reg;
  logic            in_ready;
  logic            accept;
  logic            drain;

  id_imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (bus.in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal,
                       inst: bus.in_inst, pc: bus.in_pc};

  // A word offered during a flush cycle is never captured.
  assign accept = bus.in_valid & in_ready & ~bus.flush;
  assign drain  = out_valid_reg & bus.out_ready;

  generate
    if (SKID) begin : g_skid
      skid_state_t state_reg;
      entry_t      skid_reg;
      logic        in_ready_reg;

      assign in_ready = in_ready_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          main_reg      <= '0;
          skid_reg      <= '0;
        end else if (bus.flush) begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (accept) begin
                main_reg      <= dec_entry;
                out_valid_reg <= 1'b1;
                state_reg     <= ONE;
              end
            end
            ONE: begin
              if (accept && drain) begin
                main_reg <= dec_entry;
              end else if (accept) begin
                skid_reg     <= dec_entry;
                state_reg    <= FULL;
                in_ready_reg <= 1'b0;
              end else if (drain) begin
                out_valid_reg <= 1'b0;
                state_reg     <= EMPTY;
              end
            end
            FULL: begin
              if (drain) begin
                main_reg     <= skid_reg;
                state_reg    <= ONE;
                in_ready_reg <= 1'b1;
              end
            end
            default: begin
              state_reg     <= EMPTY;
              out_valid_reg <= 1'b0;
              in_ready_reg  <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_single
      assign in_ready = ~out_valid_reg | bus.out_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_reg <= 1'b0;
          main_reg      <= '0;
        end else if (bus.flush) begin
          out_valid_reg <= 1'b0;
        end else if (accept) begin
          main_reg      <= dec_entry;
          out_valid_reg <= 1'b1;
        end else if (drain) begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_imm     = main_reg.imm;
  assign bus.out_fmt     = main_reg.fmt;
  assign bus.out_illegal = main_reg.illegal;
  assign bus.out_inst    = main_reg.inst;
  assign bus.out_pc      = main_reg.pc;

endmodule

// File: tb/tb_id_imm_gen_stage.sv
// Bench for id_imm_gen_stage: a 32-bit skid instance and a 64-bit single-register
// instance, checked every cycle against a queue model plus literal expectations.
module tb_id_imm_gen_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_imm_gen_stage_if #(.XLEN(32)) b32 ();
  id_imm_gen_stage_if #(.XLEN(64)) b64 ();

  id_imm_gen_stage #(.XLEN(32), .SKID(1'b1)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  id_imm_gen_stage #(.XLEN(64), .SKID(1'b0)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t h32, h64;
  bit   ir32, ir64, acc32, acc64, drn32, drn64;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic longint uz(input logic [31:0] x);
    return longint'({32'b0, x});
  endfunction

  // Reference immediate: weighted sum of instruction fields, sign bit counted negative.
  function automatic exp_t ref_dec(input logic [31:0] w, input logic [63:0] pc, input int xlen);
    exp_t   e;
    longint v;
    longint s;
    e.inst = w;
    e.pc   = pc;
    e.fmt  = 3'd0;
    e.ill  = 1'b0;
    v      = 0;
    s      = uz({31'b0, w[31]});
    if (w[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (w[6:0])
        7'h37, 7'h17: begin
          v = uz({12'b0, w[31:12]}) * 4096 - s * 64'sh1_0000_0000;
          e.fmt = 3'd4;
        end
        7'h6F: begin
          v = uz({22'b0, w[30:21]}) * 2 + uz({31'b0, w[20]}) * 2048
            + uz({24'b0, w[19:12]}) * 4096 - s * 1048576;
          e.fmt = 3'd5;
        end
        7'h63: begin
          v = uz({28'b0, w[11:8]}) * 2 + uz({26'b0, w[30:25]}) * 32
            + uz({31'b0, w[7]}) * 2048 - s * 4096;
          e.fmt = 3'd3;
        end
        7'h23: begin
          v = uz({27'b0, w[11:7]}) + uz({26'b0, w[30:25]}) * 32 - s * 2048;
          e.fmt = 3'd2;
        end
        7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
          v = uz({21'b0, w[30:20]}) - s * 2048;
          e.fmt = 3'd1;
        end
        7'h33: ;
        7'h1B: begin
          if (xlen == 64) begin
            v = uz({21'b0, w[30:20]}) - s * 2048;
            e.fmt = 3'd1;
          end else begin
            e.ill = 1'b1;
          end
        end
        7'h3B: if (xlen != 64) e.ill = 1'b1;
        default: e.ill = 1'b1;
      endcase
    end
    e.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_side(input string nm, input logic ov, input logic ir, input logic [63:0] imm,
                          input logic [2:0] fmt, input logic ill, input logic [31:0] inst,
                          input logic [63:0] pc, input int depth, input exp_t h, input bit exp_ir);
    chk({nm, " in_ready"}, ir, exp_ir);
    chk({nm, " out_valid"}, ov, depth > 0);
    if (depth > 0) begin
      chk({nm, " out_imm"}, imm, h.imm);
      chk({nm, " out_fmt"}, fmt, h.fmt);
      chk({nm, " out_illegal"}, ill, h.ill);
      chk({nm, " out_inst"}, inst, h.inst);
      chk({nm, " out_pc"}, pc, h.pc);
    end
  endtask

  // Per-cycle compare and model update, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      h32  = (q32.size() > 0) ? q32[0] : h32;
      h64  = (q64.size() > 0) ? q64[0] : h64;
      ir32 = (q32.size() < 2);
      ir64 = (q64.size() == 0) || b64.out_ready;
      cmp_side("u32", b32.out_valid, b32.in_ready, {32'b0, b32.out_imm}, b32.out_fmt,
               b32.out_illegal, b32.out_inst, {32'b0, b32.out_pc}, q32.size(), h32, ir32);
      cmp_side("u64", b64.out_valid, b64.in_ready, b64.out_imm, b64.out_fmt,
               b64.out_illegal, b64.out_inst, b64.out_pc, q64.size(), h64, ir64);
      acc32 = b32.in_valid && ir32 && !b32.flush;
      acc64 = b64.in_valid && ir64 && !b64.flush;
      drn32 = (q32.size() > 0) && b32.out_ready;
      drn64 = (q64.size() > 0) && b64.out_ready;
      if (drn32) $display("[TB] u32 deliver inst=%h imm=%h fmt=%0d ill=%0d", h32.inst, h32.imm[31:0], h32.fmt, h32.ill);
      if (drn64) $display("[TB] u64 deliver inst=%h imm=%h fmt=%0d ill=%0d", h64.inst, h64.imm, h64.fmt, h64.ill);
      if (b32.flush) q32.delete();
      else begin
        if (drn32) q32.delete(0);
        if (acc32) q32.push_back(ref_dec(b32.in_inst, {32'b0, b32.in_pc}, 32));
      end
      if (b64.flush) q64.delete();
      else begin
        if (drn64) q64.delete(0);
        if (acc64) q64.push_back(ref_dec(b64.in_inst, b64.in_pc, 64));
      end
    end
  end

  always @(posedge rst) begin
    q32.delete();
    q64.delete();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b32.in_valid = 1'b0; b32.flush = 1'b0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.flush = 1'b0; b64.out_ready = 1'b1;
  endtask

  task automatic lit(input bit wide, input string nm, input logic [31:0] inst,
                     input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    if (wide) begin
      chk({nm, " valid"}, b64.out_valid, 1'b1);
      chk({nm, " inst"}, b64.out_inst, inst);
      chk({nm, " imm"}, b64.out_imm, imm);
      chk({nm, " fmt"}, b64.out_fmt, fmt);
      chk({nm, " illegal"}, b64.out_illegal, ill);
    end else begin
      chk({nm, " valid"}, b32.out_valid, 1'b1);
      chk({nm, " inst"}, b32.out_inst, inst);
      chk({nm, " imm"}, {32'b0, b32.out_imm}, imm);
      chk({nm, " fmt"}, b32.out_fmt, fmt);
      chk({nm, " illegal"}, b32.out_illegal, ill);
    end
  endtask

  task automatic send_check(input bit wide, input string nm, input logic [31:0] inst,
                            input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    step();
    if (wide) begin b64.in_valid = 1'b1; b64.in_inst = inst; b64.in_pc = 64'h8000_0000_0000_0040; end
    else begin b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_pc = 32'h0000_0200; end
    step();
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
    @(negedge clk);
    lit(wide, nm, inst, imm, fmt, ill);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 15))
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73; 11: w[6:0] = 7'h1B;
      12: w[6:0] = 7'h3B; 13: w[6:0] = 7'h7F; 14: w[6:0] = 7'h0B;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    b32.in_inst = '0; b32.in_pc = '0;
    b64.in_inst = '0; b64.in_pc = '0;
    idle();
    #1 rst = 1'b1;
    #3;
    chk("rst u32 out_valid", b32.out_valid, 1'b0);
    chk("rst u32 out_imm", {32'b0, b32.out_imm}, 64'h0);
    chk("rst u32 out_fmt", b32.out_fmt, 3'd0);
    chk("rst u32 out_illegal", b32.out_illegal, 1'b0);
    chk("rst u32 out_inst", b32.out_inst, 32'h0);
    chk("rst u32 out_pc", {32'b0, b32.out_pc}, 64'h0);
    chk("rst u64 out_valid", b64.out_valid, 1'b0);
    chk("rst u64 out_pc", b64.out_pc, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back addi / sw on the 32-bit stage.
    step();
    b32.in_valid = 1'b1; b32.in_inst = 32'hFFF00093; b32.in_pc = 32'h100;
    step();
    b32.in_inst = 32'hFE112E23; b32.in_pc = 32'h104;
    @(negedge clk);
    lit(1'b0, "addi", 32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0);
    step();
    b32.in_valid = 1'b0;
    @(negedge clk);
    lit(1'b0, "sw", 32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 1'b0);

    send_check(1'b0, "beq", 32'hFE000CE3, 64'hFFFF_FFF8, 3'd3, 1'b0);
    send_check(1'b0, "jal", 32'h0010006F, 64'h0000_0800, 3'd5, 1'b0);
    send_check(1'b1, "lui64", 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    send_check(1'b1, "zero64", 32'h00000000, 64'h0, 3'd0, 1'b1);

    // Backpressure: A, B fill the skid stage, C waits upstream.
    step();
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_inst = 32'h00A00513; b32.in_pc = 32'h300;
    step();
    b32.in_inst = 32'h00C000EF; b32.in_pc = 32'h304;
    step();
    b32.in_inst = 32'h00812303; b32.in_pc = 32'h308;
    @(negedge clk);
    chk("bp in_ready after B", b32.in_ready, 1'b0);
    chk("bp head A", b32.out_inst, 32'h00A00513);
    step();
    step();
    b32.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp second B", b32.out_inst, 32'h00C000EF);
    chk("bp second valid", b32.out_valid, 1'b1);
    step();
    b32.in_valid = 1'b0;
    @(negedge clk);
    chk("bp third C", b32.out_inst, 32'h00812303);
    chk("bp third valid", b32.out_valid, 1'b1);
    step();

    // Flush while FULL with a word offered in the same cycle.
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_inst = 32'h00100093;
    step();
    b32.in_inst = 32'h00200113;
    step();
    b32.flush = 1'b1; b32.in_inst = 32'h00300193;
    step();
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    @(negedge clk);
    chk("flush out_valid", b32.out_valid, 1'b0);
    chk("flush in_ready", b32.in_ready, 1'b1);
    step();
    @(negedge clk);
    chk("flush no capture", b32.out_valid, 1'b0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      step();
      b32.in_valid  = ($urandom_range(0, 9) < 7);
      b32.in_inst   = rand_inst();
      b32.in_pc     = $urandom;
      b32.out_ready = ($urandom_range(0, 9) < 6);
      b32.flush     = ($urandom_range(0, 99) < 3);
      b64.in_valid  = ($urandom_range(0, 9) < 7);
      b64.in_inst   = rand_inst();
      b64.in_pc     = {$urandom, $urandom};
      b64.out_ready = ($urandom_range(0, 9) < 6);
      b64.flush     = ($urandom_range(0, 99) < 3);
    end

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst u32 out_valid", b32.out_valid, 1'b0);
    chk("async rst u64 out_valid", b64.out_valid, 1'b0);
    chk("async rst u32 out_inst", b32.out_inst, 32'h0);
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    send_check(1'b0, "post-rst lw", 32'hFFC12083, 64'hFFFF_FFFC, 3'd1, 1'b0);
    send_check(1'b1, "post-rst addiw", 32'h8000009B, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
